// File: rtl/ibex_multdiv_issue.sv
// Issue stage for the slow multiplier/divider: captures one M-extension op, holds the
// unit's controls stable until its result is written back, and aborts on flush or watchdog.
module ibex_multdiv_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_operator_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic        mult_sel_o,
  output logic        div_sel_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic        setback_o,
  output logic        multdiv_ready_id_o,
  input  logic        multdiv_valid_i,
  input  logic [31:0] multdiv_result_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [6:0] WD_LAST = 7'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] WD_MAX  = 7'h7f;

  state_e      state;
  logic [1:0]  operator_q;
  logic [1:0]  signed_mode_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [4:0]  rd_q;
  logic        is_div_q;
  logic [6:0]  wd_cnt;

  logic busy;
  logic accept;
  logic wd_expire;
  logic done;

  assign busy      = (state == BUSY);
  assign accept    = !busy && req_valid_i && !flush_i;
  assign wd_expire = busy && !multdiv_valid_i && (wd_cnt >= WD_LAST);
  assign done      = wb_valid_o && wb_ready_i;

  // Flush outranks both timeout and completion, so it masks timeout_o and wb_valid_o.
  assign req_ready_o        = !busy && !flush_i;
  assign setback_o          = busy && (flush_i || wd_expire);
  assign timeout_o          = wd_expire && !flush_i;
  assign wb_valid_o         = busy && multdiv_valid_i && !flush_i;
  assign multdiv_ready_id_o = busy && wb_ready_i && !flush_i;
  assign wb_data_o          = busy ? multdiv_result_i : 32'd0;
  assign wb_rd_o            = busy ? rd_q : 5'd0;
  assign busy_o             = busy;

  assign mult_en_o     = busy && !is_div_q;
  assign mult_sel_o    = busy && !is_div_q;
  assign div_en_o      = busy && is_div_q;
  assign div_sel_o     = busy && is_div_q;
  assign operator_o    = operator_q;
  assign signed_mode_o = signed_mode_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;

  // NOTE: every state register is updated with <= so all of them sample the pre-edge
  // values of each other; a blocking = here would make ordering inside the block matter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      operator_q    <= 2'd0;
      signed_mode_q <= 2'd0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      rd_q          <= 5'd0;
      is_div_q      <= 1'b0;
      wd_cnt        <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= BUSY;
            operator_q    <= req_operator_i;
            signed_mode_q <= req_signed_mode_i;
            op_a_q        <= req_op_a_i;
            op_b_q        <= req_op_b_i;
            rd_q          <= req_rd_i;
            is_div_q      <= req_operator_i[1];
            wd_cnt        <= 7'd0;
          end
        end
        BUSY: begin
          if (setback_o || done) begin
            state <= IDLE;
          end else if (!multdiv_valid_i && (wd_cnt != WD_MAX)) begin
            wd_cnt <= wd_cnt + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Bench for ibex_multdiv_issue: a stub multdiv unit plus a transaction-level model that
// predicts every DUT output each cycle, and literal expectations for the directed ops.
module tb_ibex_multdiv_issue;

  localparam int T = 64;

  localparam logic [1:0] MULL = 2'd0;
  localparam logic [1:0] MULH = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] REM  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_operator_i, req_signed_mode_i;
  logic [31:0] req_op_a_i, req_op_b_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  logic [1:0]  operator_o, signed_mode_o;
  logic [31:0] op_a_o, op_b_o;
  logic        setback_o, multdiv_ready_id_o;
  logic        multdiv_valid_i;
  logic [31:0] multdiv_result_i;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        busy_o, timeout_o;

  always #5 clk = ~clk;

  ibex_multdiv_issue #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_operator_i     (req_operator_i),
    .req_signed_mode_i  (req_signed_mode_i),
    .req_op_a_i         (req_op_a_i),
    .req_op_b_i         (req_op_b_i),
    .req_rd_i           (req_rd_i),
    .flush_i            (flush_i),
    .mult_en_o          (mult_en_o),
    .div_en_o           (div_en_o),
    .mult_sel_o         (mult_sel_o),
    .div_sel_o          (div_sel_o),
    .operator_o         (operator_o),
    .signed_mode_o      (signed_mode_o),
    .op_a_o             (op_a_o),
    .op_b_o             (op_b_o),
    .setback_o          (setback_o),
    .multdiv_ready_id_o (multdiv_ready_id_o),
    .multdiv_valid_i    (multdiv_valid_i),
    .multdiv_result_i   (multdiv_result_i),
    .wb_valid_o         (wb_valid_o),
    .wb_ready_i         (wb_ready_i),
    .wb_rd_o            (wb_rd_o),
    .wb_data_o          (wb_data_o),
    .busy_o             (busy_o),
    .timeout_o          (timeout_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic for the stub unit's result.
  function automatic logic [31:0] md_ref(input logic [1:0] op, input logic [1:0] sm,
                                         input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] p;
    sa = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
    case (op)
      MULL: return a * b;
      MULH: begin
        p = 64'(sa * sb);
        return p[63:32];
      end
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return 32'(sa / sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return 32'(sa % sb);
      end
    endcase
  endfunction

  // Transaction model: is an op in flight, what was captured, how many non-valid cycles.
  logic        m_busy;
  logic [1:0]  m_op, m_sm;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  int          m_nv;

  // Stub unit: result valid once the op has been enabled for s_lat cycles.
  int          s_lat = 1000;
  int          s_cnt = 0;
  logic [31:0] s_res = 32'd0;

  // Per-op event record.
  int          n_sb, n_to, n_wbv, n_done, to_at, v_at, bcyc;
  logic [31:0] got_data;
  logic [4:0]  got_rd;

  task automatic model_reset();
    m_busy = 1'b0; m_op = 2'd0; m_sm = 2'd0; m_a = 32'd0; m_b = 32'd0; m_rd = 5'd0; m_nv = 0;
    s_cnt = 0;
  endtask

  task automatic cycle();
    logic         e_to, e_wbv;
    logic [127:0] exp_ctl, exp_hold, exp_wb;
    #1;
    if (rst) model_reset();
    multdiv_valid_i  = (mult_en_o || div_en_o) && (s_cnt + 1 >= s_lat);
    multdiv_result_i = multdiv_valid_i ? s_res : (32'hDEAD_0000 ^ 32'(s_cnt));
    #1;
    e_to  = m_busy && !flush_i && !multdiv_valid_i && (m_nv == T - 1);
    e_wbv = m_busy && multdiv_valid_i && !flush_i;
    exp_ctl  = 128'({!m_busy && !flush_i,
                     m_busy && !m_op[1], m_busy && m_op[1],
                     m_busy && !m_op[1], m_busy && m_op[1],
                     m_busy && (flush_i || e_to),
                     m_busy && wb_ready_i && !flush_i,
                     e_wbv, m_busy, e_to});
    exp_hold = 128'({m_op, m_sm, m_a, m_b});
    exp_wb   = 128'({m_busy ? m_rd : 5'd0, m_busy ? multdiv_result_i : 32'd0});
    check("ctl", 128'({req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, setback_o,
                       multdiv_ready_id_o, wb_valid_o, busy_o, timeout_o}), exp_ctl);
    check("hold", 128'({operator_o, signed_mode_o, op_a_o, op_b_o}), exp_hold);
    check("wb", 128'({wb_rd_o, wb_data_o}), exp_wb);

    if (setback_o) n_sb++;
    if (timeout_o) begin n_to++; to_at = bcyc; end
    if (wb_valid_o) begin
      n_wbv++;
      if (v_at == 0) v_at = bcyc;
    end
    if (wb_valid_o && wb_ready_i) begin n_done++; got_data = wb_data_o; got_rd = wb_rd_o; end

    if (!(mult_en_o || div_en_o) || setback_o || (wb_valid_o && wb_ready_i)) s_cnt = 0;
    else s_cnt++;

    if (!rst) begin
      if (m_busy) begin
        if (flush_i || e_to || (e_wbv && wb_ready_i)) m_busy = 1'b0;
        else if (!multdiv_valid_i) m_nv++;
      end else if (req_valid_i && !flush_i) begin
        m_busy = 1'b1; m_op = req_operator_i; m_sm = req_signed_mode_i;
        m_a = req_op_a_i; m_b = req_op_b_i; m_rd = req_rd_i; m_nv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sm,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input int lat, input int stall, input int flush_at, input int rst_at);
    int k;
    n_sb = 0; n_to = 0; n_wbv = 0; n_done = 0; to_at = 0; v_at = 0; bcyc = 0;
    got_data = 32'd0; got_rd = 5'd0;
    s_lat = lat;
    s_res = md_ref(op, sm, a, b);
    req_valid_i = 1'b1; req_operator_i = op; req_signed_mode_i = sm;
    req_op_a_i = a; req_op_b_i = b; req_rd_i = rd;
    flush_i = 1'b0; wb_ready_i = 1'b1;
    cycle();
    // Keep a different request pending so holding and non-acceptance are both exercised.
    req_operator_i = ~op; req_signed_mode_i = ~sm;
    req_op_a_i = ~a; req_op_b_i = b ^ 32'h5A5A_5A5A; req_rd_i = ~rd;
    k = 1;
    while (busy_o && k <= 200) begin
      bcyc = k;
      flush_i = (k == flush_at);
      wb_ready_i = (n_wbv >= stall);
      if (k == rst_at) rst = 1'b1;
      cycle();
      rst = 1'b0;
      k++;
    end
    check("busy_bound", 128'(busy_o), 128'(0));
    req_valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1; bcyc = 0;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0; req_operator_i = 2'd0; req_signed_mode_i = 2'd0;
    req_op_a_i = 32'd0; req_op_b_i = 32'd0; req_rd_i = 5'd0;
    flush_i = 1'b0; wb_ready_i = 1'b0;
    multdiv_valid_i = 1'b0; multdiv_result_i = 32'd0;
    model_reset();
    cycle();
    cycle();
    check("rst_req_ready", 128'(req_ready_o), 128'(1));
    check("rst_busy", 128'(busy_o), 128'(0));
    rst = 1'b0;
    cycle();

    issue(MULL, 2'b00, 32'd7, 32'd6, 5'd9, 3, 0, 0, 0);
    check("mull_data", 128'(got_data), 128'(42));
    check("mull_rd", 128'(got_rd), 128'(9));
    check("mull_done", 128'(n_done), 128'(1));

    issue(DIV, 2'b11, 32'hFFFF_FFEC, 32'd3, 5'd4, 37, 0, 0, 0);
    check("div_data", 128'(got_data), 128'(32'hFFFF_FFFA));
    check("div_lat", 128'(v_at), 128'(37));

    issue(MULH, 2'b11, 32'h8000_0000, 32'd2, 5'd12, 33, 0, 0, 0);
    check("mulh_s_data", 128'(got_data), 128'(32'hFFFF_FFFF));

    issue(MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 33, 0, 0, 0);
    check("mulh_u_data", 128'(got_data), 128'(32'hFFFF_FFFE));

    issue(REM, 2'b11, 32'h0000_1234, 32'd0, 5'd20, 2, 0, 0, 0);
    check("rem0_data", 128'(got_data), 128'(32'h1234));
    check("rem0_lat", 128'(v_at), 128'(2));

    issue(DIV, 2'b11, 32'd77, 32'd0, 5'd21, 2, 0, 0, 0);
    check("div0_data", 128'(got_data), 128'(32'hFFFF_FFFF));

    issue(MULL, 2'b00, 32'd100, 32'd3, 5'd17, 5, 10, 0, 0);
    check("stall_data", 128'(got_data), 128'(300));
    check("stall_rd", 128'(got_rd), 128'(17));
    check("stall_valid_cycles", 128'(n_wbv), 128'(11));
    check("stall_done", 128'(n_done), 128'(1));

    issue(DIV, 2'b00, 32'd1000, 32'd7, 5'd3, 37, 0, 10, 0);
    check("flush_setback", 128'(n_sb), 128'(1));
    check("flush_no_wb", 128'(n_wbv), 128'(0));

    issue(MULL, 2'b00, 32'd3, 32'd5, 5'd6, 4, 0, 0, 0);
    check("post_flush_data", 128'(got_data), 128'(15));

    issue(MULL, 2'b00, 32'd9, 32'd9, 5'd7, 4, 0, 4, 0);
    check("flush_on_valid_done", 128'(n_done), 128'(0));
    check("flush_on_valid_sb", 128'(n_sb), 128'(1));

    issue(DIV, 2'b11, 32'd50, 32'd5, 5'd8, 1000, 0, 0, 0);
    check("wd_timeout", 128'(n_to), 128'(1));
    check("wd_cycle", 128'(to_at), 128'(64));
    check("wd_setback", 128'(n_sb), 128'(1));
    check("wd_no_wb", 128'(n_done), 128'(0));
    check("wd_req_ready", 128'(req_ready_o), 128'(1));

    issue(DIV, 2'b00, 32'd81, 32'd9, 5'd10, 37, 0, 0, 5);
    check("rst_mid_done", 128'(n_done), 128'(0));
    check("rst_mid_sb", 128'(n_sb), 128'(0));

    req_valid_i = 1'b1; req_operator_i = MULL; req_op_a_i = 32'd2; req_op_b_i = 32'd2;
    flush_i = 1'b1;
    cycle();
    check("idle_flush_busy", 128'(busy_o), 128'(0));
    req_valid_i = 1'b0; flush_i = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
